// File: rtl/frontend_pkg.sv
// frontend_pkg: shared front-end types, default widths and the PC-to-BTB-key helper
package frontend_pkg;
   localparam int XLEN_DEFAULT = 32;
   localparam int BTB_KEY_WIDTH_DEFAULT = 30;
   typedef struct packed {
      logic                             valid;
      logic [BTB_KEY_WIDTH_DEFAULT-1:0] key;
      logic [XLEN_DEFAULT-1:0]          value;
   } btb_update_t;
   typedef enum logic {S_INIT, S_RUN} fetch_pc_state_t;
   function automatic logic [BTB_KEY_WIDTH_DEFAULT-1:0] pc_to_btb_key(input logic [XLEN_DEFAULT-1:0] pc);
      return pc[BTB_KEY_WIDTH_DEFAULT+1:2];
   endfunction
endpackage

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC register, BTB-predicted next-PC selection and registered BTB update writes
//   req_*        fetch request handshake toward the fetch unit (req_pc, prediction)
//   redirect_*   execute redirect, always wins over the handshake
//   resolve_*    branch resolution, turned into a 1-cycle-late BTB write
//   btb_*        combinational lookup key/result and registered update to the parent's store
//   perf_*       wrapping counters of accepted requests and accepted predicted-taken requests
module fetch_pc_gen
   import frontend_pkg::*;
#(
   parameter int              XLEN          = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_VECTOR  = '0,
   parameter int              BTB_KEY_WIDTH = BTB_KEY_WIDTH_DEFAULT,
   parameter int              CNT_WIDTH     = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     req_valid,
   input  logic                     req_ready,
   output logic [XLEN-1:0]          req_pc,
   output logic                     req_pred_taken,
   output logic [XLEN-1:0]          req_pred_next,
   input  logic                     redirect_valid,
   input  logic [XLEN-1:0]          redirect_pc,
   input  logic                     resolve_valid,
   input  logic [XLEN-1:0]          resolve_pc,
   input  logic                     resolve_taken,
   input  logic [XLEN-1:0]          resolve_target,
   output logic [BTB_KEY_WIDTH-1:0] btb_key,
   input  logic                     btb_hit,
   input  logic [XLEN-1:0]          btb_value,
   output logic                     btb_update_valid,
   output logic [BTB_KEY_WIDTH-1:0] btb_update_key,
   output logic [XLEN-1:0]          btb_update_value,
   output logic [CNT_WIDTH-1:0]     perf_fetch_cnt,
   output logic [CNT_WIDTH-1:0]     perf_pred_taken_cnt
);
   if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_reset_vector
      $fatal(1, "fetch_pc_gen: RESET_VECTOR must be 4-byte aligned");
   end
   if (BTB_KEY_WIDTH > XLEN - 2) begin : g_bad_key_width
      $fatal(1, "fetch_pc_gen: BTB_KEY_WIDTH must not exceed XLEN-2");
   end
   fetch_pc_state_t state_q;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            hs;
   logic            upd;
   logic            unused_bits;
   assign btb_key        = pc_q[BTB_KEY_WIDTH+1:2];
   assign req_pc         = pc_q;
   assign req_pred_taken = btb_hit;
   assign req_pred_next  = btb_hit ? {btb_value[XLEN-1:2], 2'b00} : pc_q + XLEN'(4);
   assign req_valid      = (state_q == S_RUN) && !redirect_valid;
   assign hs             = req_valid && req_ready;
   assign upd            = resolve_valid && resolve_taken;
   assign pc_d           = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : hs ? req_pred_next : pc_q;
   // Low bits are forced to zero on every stored PC; the resolve PC only contributes its key slice.
   assign unused_bits    = ^{redirect_pc[1:0], btb_value[1:0], resolve_pc, resolve_target[1:0]};
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q             <= S_INIT;
         pc_q                <= RESET_VECTOR;
         btb_update_valid    <= 1'b0;
         btb_update_key      <= '0;
         btb_update_value    <= '0;
         perf_fetch_cnt      <= '0;
         perf_pred_taken_cnt <= '0;
      end else begin
         state_q          <= S_RUN;
         pc_q             <= pc_d;
         btb_update_valid <= upd;
         if (upd) begin
            btb_update_key   <= resolve_pc[BTB_KEY_WIDTH+1:2];
            btb_update_value <= {resolve_target[XLEN-1:2], 2'b00};
         end
         if (hs) begin
            perf_fetch_cnt <= perf_fetch_cnt + CNT_WIDTH'(1);
            if (btb_hit) perf_pred_taken_cnt <= perf_pred_taken_cnt + CNT_WIDTH'(1);
         end
      end
   end
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed vector table plus randomized traffic checked against a behavioural model
module tb_fetch_pc_gen;
   logic        clk, reset;
   logic        req_valid, req_ready, req_pred_taken;
   logic [31:0] req_pc, req_pred_next;
   logic        redirect_valid, resolve_valid, resolve_taken;
   logic [31:0] redirect_pc, resolve_pc, resolve_target;
   logic [29:0] btb_key, btb_update_key;
   logic        btb_hit, btb_update_valid;
   logic [31:0] btb_value, btb_update_value, perf_fetch_cnt, perf_pred_taken_cnt;

   fetch_pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .BTB_KEY_WIDTH(30), .CNT_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
      .req_pred_taken(req_pred_taken), .req_pred_next(req_pred_next),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
      .resolve_taken(resolve_taken), .resolve_target(resolve_target),
      .btb_key(btb_key), .btb_hit(btb_hit), .btb_value(btb_value),
      .btb_update_valid(btb_update_valid), .btb_update_key(btb_update_key),
      .btb_update_value(btb_update_value),
      .perf_fetch_cnt(perf_fetch_cnt), .perf_pred_taken_cnt(perf_pred_taken_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst, rdy, rdv;
      logic [31:0] rdpc;
      logic        rsv, rtk;
      logic [31:0] rspc, rstgt;
      logic        chk, ev;
      logic [31:0] epc;
      logic        ept;
      logic [31:0] enx;
      logic        euv;
      logic [29:0] euk;
      logic [31:0] euval, efc, epcnt;
   } vec_t;

   vec_t tbl[$];
   int   n_chk = 0, n_fail = 0;

   // parent-side store driven by the DUT's update port
   logic [31:0] env_btb [logic [29:0]];
   // reference model state
   logic [31:0] m_store [logic [29:0]];
   bit          m_known = 0, m_run = 0, m_uv = 0;
   logic [31:0] m_pc = 0, m_fc = 0, m_pt = 0, m_uval = 0;
   logic [29:0] m_uk = 0;

   task automatic add(input logic rst, rdy, rdv, input logic [31:0] rdpc, input logic rsv, rtk,
                      input logic [31:0] rspc, rstgt, input logic chk, ev, input logic [31:0] epc,
                      input logic ept, input logic [31:0] enx, input logic euv, input logic [29:0] euk,
                      input logic [31:0] euval, efc, epcnt);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.rdv = rdv; v.rdpc = rdpc; v.rsv = rsv; v.rtk = rtk;
      v.rspc = rspc; v.rstgt = rstgt; v.chk = chk; v.ev = ev; v.epc = epc; v.ept = ept;
      v.enx = enx; v.euv = euv; v.euk = euk; v.euval = euval; v.efc = efc; v.epcnt = epcnt;
      tbl.push_back(v);
   endtask

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input vec_t v);
      logic [29:0] mk;
      bit          mhit, hs;
      logic [31:0] mnext;
      reset = v.rst; req_ready = v.rdy; redirect_valid = v.rdv; redirect_pc = v.rdpc;
      resolve_valid = v.rsv; resolve_taken = v.rtk; resolve_pc = v.rspc; resolve_target = v.rstgt;
      btb_hit = m_known && env_btb.exists(btb_key);
      btb_value = btb_hit ? env_btb[btb_key] : 32'h0;
      #3;
      mk = m_pc[31:2];
      mhit = m_store.exists(mk);
      mnext = mhit ? m_store[mk] : m_pc + 32'd4;
      if (m_known) begin
         cmp("req_valid", {31'b0, req_valid}, {31'b0, m_run && !v.rdv});
         cmp("req_pc", req_pc, m_pc);
         cmp("btb_key", {2'b0, btb_key}, {2'b0, mk});
         cmp("req_pred_taken", {31'b0, req_pred_taken}, {31'b0, mhit});
         cmp("req_pred_next", req_pred_next, mnext);
         cmp("btb_update_valid", {31'b0, btb_update_valid}, {31'b0, m_uv});
         cmp("btb_update_key", {2'b0, btb_update_key}, {2'b0, m_uk});
         cmp("btb_update_value", btb_update_value, m_uval);
         cmp("perf_fetch_cnt", perf_fetch_cnt, m_fc);
         cmp("perf_pred_taken_cnt", perf_pred_taken_cnt, m_pt);
      end
      if (v.chk) begin
         cmp("tbl_req_valid", {31'b0, req_valid}, {31'b0, v.ev});
         cmp("tbl_req_pc", req_pc, v.epc);
         cmp("tbl_pred_taken", {31'b0, req_pred_taken}, {31'b0, v.ept});
         cmp("tbl_pred_next", req_pred_next, v.enx);
         cmp("tbl_upd_valid", {31'b0, btb_update_valid}, {31'b0, v.euv});
         cmp("tbl_upd_key", {2'b0, btb_update_key}, {2'b0, v.euk});
         cmp("tbl_upd_value", btb_update_value, v.euval);
         cmp("tbl_fetch_cnt", perf_fetch_cnt, v.efc);
         cmp("tbl_pred_cnt", perf_pred_taken_cnt, v.epcnt);
      end
      if (btb_update_valid === 1'b1) env_btb[btb_update_key] = btb_update_value;
      if (m_uv) m_store[m_uk] = m_uval;
      if (v.rst) begin
         m_known = 1; m_run = 0; m_pc = 0; m_fc = 0; m_pt = 0; m_uv = 0; m_uk = 0; m_uval = 0;
      end else begin
         hs = m_run && !v.rdv && v.rdy;
         if (hs) begin
            m_fc++;
            if (mhit) m_pt++;
         end
         m_pc = v.rdv ? {v.rdpc[31:2], 2'b00} : hs ? mnext : m_pc;
         m_run = 1;
         m_uv = v.rsv && v.rtk;
         if (m_uv) begin
            m_uk = v.rspc[31:2];
            m_uval = {v.rstgt[31:2], 2'b00};
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t r;
      reset = 1; req_ready = 0; redirect_valid = 0; redirect_pc = 0; resolve_valid = 0;
      resolve_taken = 0; resolve_pc = 0; resolve_target = 0; btb_hit = 0; btb_value = 0;
      //  rst rdy rdv rdpc          rsv rtk rspc   rstgt   chk v  pc            pt next          uv uk uval    fc pc
      add(1, 0, 0, 0,             0, 0, 0,     0,      0, 0, 0,            0, 0,            0, 0, 0,      0, 0);
      add(1, 0, 0, 0,             0, 0, 0,     0,      1, 0, 0,            0, 4,            0, 0, 0,      0, 0);
      add(1, 0, 0, 0,             0, 0, 0,     0,      1, 0, 0,            0, 4,            0, 0, 0,      0, 0);
      add(0, 1, 0, 0,             0, 0, 0,     0,      1, 0, 0,            0, 4,            0, 0, 0,      0, 0);
      add(0, 1, 0, 0,             0, 0, 0,     0,      1, 1, 0,            0, 4,            0, 0, 0,      0, 0);
      add(0, 1, 0, 0,             0, 0, 0,     0,      1, 1, 4,            0, 8,            0, 0, 0,      1, 0);
      add(0, 1, 0, 0,             1, 1, 'h10,  'h103,  1, 1, 8,            0, 'hC,          0, 0, 0,      2, 0);
      add(0, 0, 0, 0,             0, 0, 0,     0,      1, 1, 'hC,          0, 'h10,         1, 4, 'h100,  3, 0);
      add(0, 1, 0, 0,             0, 0, 0,     0,      1, 1, 'hC,          0, 'h10,         0, 4, 'h100,  3, 0);
      add(0, 1, 0, 0,             0, 0, 0,     0,      1, 1, 'h10,         1, 'h100,        0, 4, 'h100,  4, 0);
      add(0, 0, 1, 'h20,          0, 0, 0,     0,      1, 0, 'h100,        0, 'h104,        0, 4, 'h100,  5, 1);
      add(0, 0, 0, 0,             0, 0, 0,     0,      1, 1, 'h20,         0, 'h24,         0, 4, 'h100,  5, 1);
      add(0, 0, 1, 'h202,         0, 0, 0,     0,      1, 0, 'h20,         0, 'h24,         0, 4, 'h100,  5, 1);
      add(0, 1, 1, 'h300,         1, 0, 'h40,  'h80,   1, 0, 'h200,        0, 'h204,        0, 4, 'h100,  5, 1);
      add(0, 1, 0, 0,             0, 0, 0,     0,      1, 1, 'h300,        0, 'h304,        0, 4, 'h100,  5, 1);
      add(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0,     0,      1, 0, 'h304,        0, 'h308,        0, 4, 'h100,  6, 1);
      add(0, 1, 0, 0,             0, 0, 0,     0,      1, 1, 32'hFFFF_FFFC, 0, 0,           0, 4, 'h100,  6, 1);
      add(0, 0, 0, 0,             1, 1, 0,     8,      1, 1, 0,            0, 4,            0, 4, 'h100,  7, 1);
      add(1, 1, 0, 0,             1, 1, 4,     'h40,   1, 1, 0,            0, 4,            1, 0, 8,      7, 1);
      add(0, 1, 0, 0,             0, 0, 0,     0,      1, 0, 0,            1, 8,            0, 0, 0,      0, 0);
      add(0, 1, 0, 0,             0, 0, 0,     0,      1, 1, 0,            1, 8,            0, 0, 0,      0, 0);
      add(0, 1, 0, 0,             0, 0, 0,     0,      1, 1, 8,            0, 'hC,          0, 0, 0,      1, 1);
      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
      for (int i = 0; i < 800; i++) begin
         r.rst = ($urandom % 60) == 0;
         r.rdy = ($urandom % 4) != 0;
         r.rdv = ($urandom % 8) == 0;
         r.rdpc = (($urandom % 16) == 0) ? 32'hFFFF_FFF0 | ($urandom % 16) : $urandom % 256;
         r.rsv = ($urandom % 3) == 0;
         r.rtk = ($urandom % 2) == 0;
         r.rspc = $urandom % 256;
         r.rstgt = $urandom % 512;
         r.chk = 0; r.ev = 0; r.epc = 0; r.ept = 0; r.enx = 0; r.euv = 0; r.euk = 0;
         r.euval = 0; r.efc = 0; r.epcnt = 0;
         step(r);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
